// File: rtl/pipe_ctrl_chain_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_chain_pkg
//   Shared definitions for the post-decode control pipeline:
//   - default widths/depth for the chain
//   - bit offsets of the fields packed into the control payload
//   - the bubble (NOP) encoding loaded into a stage when nothing issues
// -----------------------------------------------------------------------------
package pipe_ctrl_chain_pkg;

    // Default geometry of the chain.
    localparam int unsigned PIPE_W_DEF     = 16;  // control payload width
    localparam int unsigned PIPE_DEPTH_DEF = 3;   // EX, MEM, WB
    localparam int unsigned PIPE_REGW_DEF  = 4;   // register index width

    // Field offsets inside the control payload (bits 15:13 reserved).
    localparam int unsigned CTRL_ALU_OP_LSB = 0;   // [3:0]  ALU operation
    localparam int unsigned CTRL_SHIFT_LSB  = 4;   // [7:4]  shift type/amount
    localparam int unsigned CTRL_SIZE_LSB   = 8;   // [9:8]  access size
    localparam int unsigned CTRL_MEM_EN_BIT = 10;  // memory access enable
    localparam int unsigned CTRL_RW_BIT     = 11;  // 1 = write, 0 = read
    localparam int unsigned CTRL_S_BIT      = 12;  // update flags

    // Per-stage qualifier flags travel together.
    typedef struct packed {
        logic valid;
        logic rf_en;
        logic load;
    } stg_flags_t;

    // Bubble encoding. Payload/index constants are wide enough for any legal
    // configuration (W, REGW <= 64) and are sliced to size at the point of use.
    localparam stg_flags_t  FLAGS_BUBBLE = '0;
    localparam logic [63:0] CTRL_BUBBLE  = '0;
    localparam logic [63:0] RD_BUBBLE    = '0;

endpackage : pipe_ctrl_chain_pkg

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   One stage of the post-decode control pipeline: payload, destination index
//   and qualifier flags. Loads its inputs every rising edge unless i_bubble is
//   set, in which case it loads the bubble encoding. CLR clears asynchronously.
//
//   Ports
//     CLK, CLR          clock, asynchronous active-high clear
//     i_bubble          1 = load bubble instead of inputs
//     i_ctrl/i_rd       incoming payload and destination index
//     i_valid/i_rf_en/i_load  incoming flags
//     o_*               registered stage contents
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_ctrl_chain_pkg::*;
#(
    parameter int unsigned W    = PIPE_W_DEF,
    parameter int unsigned REGW = PIPE_REGW_DEF
) (
    input  logic            CLK,
    input  logic            CLR,
    input  logic            i_bubble,
    input  logic [W-1:0]    i_ctrl,
    input  logic            i_valid,
    input  logic            i_rf_en,
    input  logic            i_load,
    input  logic [REGW-1:0] i_rd,
    output logic [W-1:0]    o_ctrl,
    output logic            o_valid,
    output logic            o_rf_en,
    output logic            o_load,
    output logic [REGW-1:0] o_rd
);

    logic [W-1:0]    r_ctrl;
    logic [REGW-1:0] r_rd;
    stg_flags_t      r_flags;

    // NOTE: every field is cleared, not just valid -- downstream hazard and
    // write-back logic reads rd/rf_en/load directly and must never see stale
    // values after CLR.
    // NOTE: sequential state uses non-blocking assignments so all stages
    // sample the pre-edge values of their neighbours and shift in lock-step.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_ctrl  <= CTRL_BUBBLE[W-1:0];
            r_rd    <= RD_BUBBLE[REGW-1:0];
            r_flags <= FLAGS_BUBBLE;
        end else if (i_bubble) begin
            r_ctrl  <= CTRL_BUBBLE[W-1:0];
            r_rd    <= RD_BUBBLE[REGW-1:0];
            r_flags <= FLAGS_BUBBLE;
        end else begin
            r_ctrl  <= i_ctrl;
            r_rd    <= i_rd;
            r_flags <= '{valid: i_valid, rf_en: i_rf_en, load: i_load};
        end
    end

    assign o_ctrl  = r_ctrl;
    assign o_rd    = r_rd;
    assign o_valid = r_flags.valid;
    assign o_rf_en = r_flags.rf_en;
    assign o_load  = r_flags.load;

endmodule : pipe_stage_reg

// File: rtl/pipe_ctrl_chain.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_chain
//   Control-signal pipeline following the decode stage. DEPTH stages
//   (stage 0 = EX) shift every cycle and never freeze; decode is held instead.
//   A load in EX whose destination is read by the instruction in decode
//   raises stall_o for one cycle and a bubble enters EX. A taken branch
//   flushes IF/ID and also bubbles EX; it wins over a stall. Saturating
//   counters record stall and flush cycles. DEPTH legal range is 2..8.
//
//   Ports
//     CLK, CLR               clock, asynchronous active-high clear
//     id_valid/id_ctrl/id_rd/id_rf_en/id_load   decode-stage instruction
//     id_rn/id_rm, id_rn_use/id_rm_use          source indices and usage
//     br_taken               branch resolved taken in EX
//     stall_o, flush_o       hold PC + IF/ID, clear IF/ID
//     stg_ctrl/stg_rd        per-stage payload/index, stage k at [k*W +: W]
//     stg_valid/stg_rf_en/stg_load   per-stage flags
//     stall_cnt, flush_cnt   saturating 16-bit event counters
// -----------------------------------------------------------------------------
module pipe_ctrl_chain
    import pipe_ctrl_chain_pkg::*;
#(
    parameter int unsigned W     = PIPE_W_DEF,
    parameter int unsigned DEPTH = PIPE_DEPTH_DEF,
    parameter int unsigned REGW  = PIPE_REGW_DEF
) (
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic                  id_valid,
    input  logic [W-1:0]          id_ctrl,
    input  logic [REGW-1:0]       id_rd,
    input  logic                  id_rf_en,
    input  logic                  id_load,
    input  logic [REGW-1:0]       id_rn,
    input  logic [REGW-1:0]       id_rm,
    input  logic                  id_rn_use,
    input  logic                  id_rm_use,
    input  logic                  br_taken,
    output logic                  stall_o,
    output logic                  flush_o,
    output logic [DEPTH*W-1:0]    stg_ctrl,
    output logic [DEPTH-1:0]      stg_valid,
    output logic [DEPTH-1:0]      stg_rf_en,
    output logic [DEPTH-1:0]      stg_load,
    output logic [DEPTH*REGW-1:0] stg_rd,
    output logic [15:0]           stall_cnt,
    output logic [15:0]           flush_cnt
);

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Stage outputs, indexed by stage number.
    logic [W-1:0]    w_ctrl  [DEPTH];
    logic [REGW-1:0] w_rd    [DEPTH];
    logic            w_valid [DEPTH];
    logic            w_rf_en [DEPTH];
    logic            w_load  [DEPTH];

    logic w_hazard;
    logic w_issue;

    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    // ---------------------------------------------------------------------
    // Load-use hazard: EX holds a valid load writing a register that the
    // decode-stage instruction actually reads.
    // ---------------------------------------------------------------------
    // NOTE: the default assignment first keeps this block purely
    // combinational; a path that left w_hazard unassigned would infer a latch.
    always_comb begin
        w_hazard = 1'b0;
        if (id_valid && w_valid[0] && w_load[0] && w_rf_en[0]) begin
            w_hazard = (id_rn_use && (id_rn == w_rd[0])) ||
                       (id_rm_use && (id_rm == w_rd[0]));
        end
    end

    // Gated with CLR so both strobes are quiet during reset.
    assign stall_o = w_hazard & ~br_taken & ~CLR;
    assign flush_o = br_taken & ~CLR;

    // Decode issues into EX only when nothing blocks or kills it.
    assign w_issue = id_valid & ~stall_o & ~br_taken;

    // ---------------------------------------------------------------------
    // Stage chain: stage 0 is fed from decode, stage k from stage k-1.
    // ---------------------------------------------------------------------
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            pipe_stage_reg #(.W(W), .REGW(REGW)) u_stage (
                .CLK     (CLK),
                .CLR     (CLR),
                .i_bubble(~w_issue),
                .i_ctrl  (id_ctrl),
                .i_valid (id_valid),
                .i_rf_en (id_rf_en),
                .i_load  (id_load),
                .i_rd    (id_rd),
                .o_ctrl  (w_ctrl[k]),
                .o_valid (w_valid[k]),
                .o_rf_en (w_rf_en[k]),
                .o_load  (w_load[k]),
                .o_rd    (w_rd[k])
            );
        end else begin : g_body
            pipe_stage_reg #(.W(W), .REGW(REGW)) u_stage (
                .CLK     (CLK),
                .CLR     (CLR),
                .i_bubble(1'b0),
                .i_ctrl  (w_ctrl[k-1]),
                .i_valid (w_valid[k-1]),
                .i_rf_en (w_rf_en[k-1]),
                .i_load  (w_load[k-1]),
                .i_rd    (w_rd[k-1]),
                .o_ctrl  (w_ctrl[k]),
                .o_valid (w_valid[k]),
                .o_rf_en (w_rf_en[k]),
                .o_load  (w_load[k]),
                .o_rd    (w_rd[k])
            );
        end

        assign stg_ctrl[k*W +: W]       = w_ctrl[k];
        assign stg_rd[k*REGW +: REGW]   = w_rd[k];
        assign stg_valid[k]             = w_valid[k];
        assign stg_rf_en[k]             = w_rf_en[k];
        assign stg_load[k]              = w_load[k];
    end

    // ---------------------------------------------------------------------
    // Saturating event counters.
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall_o && (r_stall_cnt != CNT_MAX)) r_stall_cnt <= r_stall_cnt + 16'd1;
            if (flush_o && (r_flush_cnt != CNT_MAX)) r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule : pipe_ctrl_chain
